// File: rtl/wb_intercon.sv
// rtl/wb_intercon.sv - single-master Wishbone interconnect with address decode and bus timeout
module wb_intercon #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_m_addr,
  input  logic [31:0] i_m_data,
  input  logic        i_m_we,
  input  logic        i_m_cyc,
  input  logic        i_m_stb,
  input  logic [1:0]  i_m_width,
  output logic [31:0] o_m_data,
  output logic        o_m_ack,
  output logic        o_m_stl,
  output logic        o_m_err,
  output logic [31:0] o_s_addr,
  output logic [31:0] o_s_data,
  output logic        o_s_we,
  output logic        o_s_cyc,
  output logic [1:0]  o_s_width,
  output logic [2:0]  o_s_stb,
  input  logic [2:0]  i_s_ack,
  input  logic [2:0]  i_s_stl,
  input  logic [31:0] i_s0_data,
  input  logic [31:0] i_s1_data,
  input  logic [31:0] i_s2_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  // A stalled request in IDLE is counted from its first cycle, while a WAIT
  // count starts one cycle after acceptance; the two limits differ by one so
  // that the error lands TIMEOUT cycles after the request in both cases.
  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT - 1);
  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 2);

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next, cnt_inc;
  logic [1:0]  sel_reg, sel_next;
  logic [1:0]  dec_sel;
  logic        dec_hit;
  logic [2:0]  dec_onehot;
  logic        dec_stl;
  logic        sel_ack;
  logic [31:0] sel_data;
  logic        req;
  logic [2:0]  s_stb;
  logic        m_ack, m_stl, m_err;
  logic [31:0] m_data;

  assign o_s_addr  = i_m_addr;
  assign o_s_data  = i_m_data;
  assign o_s_we    = i_m_we;
  assign o_s_cyc   = i_m_cyc;
  assign o_s_width = i_m_width;

  assign req     = i_m_cyc & i_m_stb;
  assign cnt_inc = (cnt == 16'hffff) ? cnt : cnt + 16'd1;

  // Response outputs and strobes are forced quiet while reset is held.
  assign o_s_stb  = reset ? s_stb  : 3'b000;
  assign o_m_ack  = reset & m_ack;
  assign o_m_stl  = reset & m_stl;
  assign o_m_err  = reset & m_err;
  assign o_m_data = reset ? m_data : 32'd0;

  // Address decode of the live master request into a slave index.
  always_comb begin
    dec_hit = 1'b1;
    dec_sel = 2'd0;
    if (i_m_addr[31:15] == 17'h16000) begin
      dec_sel = 2'd0;
    end else if (i_m_addr[31:15] == 17'h16001) begin
      dec_sel = 2'd1;
    end else if (i_m_addr[31:16] == 16'hc000) begin
      dec_sel = 2'd2;
    end else begin
      dec_hit = 1'b0;
    end
  end

  // Per-slave selection: strobe and stall for the decoded slave, ack and data for the registered one.
  always_comb begin
    dec_onehot = 3'b000;
    dec_stl    = 1'b0;
    sel_ack    = 1'b0;
    sel_data   = 32'd0;
    case (dec_sel)
      2'd0:    begin dec_onehot = 3'b001; dec_stl = i_s_stl[0]; end
      2'd1:    begin dec_onehot = 3'b010; dec_stl = i_s_stl[1]; end
      2'd2:    begin dec_onehot = 3'b100; dec_stl = i_s_stl[2]; end
      default: ;
    endcase
    case (sel_reg)
      2'd0:    begin sel_ack = i_s_ack[0]; sel_data = i_s0_data; end
      2'd1:    begin sel_ack = i_s_ack[1]; sel_data = i_s1_data; end
      2'd2:    begin sel_ack = i_s_ack[2]; sel_data = i_s2_data; end
      default: ;
    endcase
  end

  // State, timeout counter and selected-slave registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      sel_reg <= 2'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      sel_reg <= sel_next;
    end
  end

  // Next-state logic and master/slave handshake outputs.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sel_next   = sel_reg;
    s_stb      = 3'b000;
    m_ack      = 1'b0;
    m_stl      = 1'b0;
    m_err      = 1'b0;
    m_data     = 32'd0;
    case (state)
      IDLE: begin
        cnt_next = 16'd0;
        if (req) begin
          if (dec_hit) begin
            s_stb = dec_onehot;
            m_stl = dec_stl;
            if (!dec_stl) begin
              sel_next   = dec_sel;
              state_next = WAIT;
            end else if (cnt >= IDLE_LIMIT) begin
              state_next = ERR;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            m_stl      = 1'b1;
            state_next = ERR;
          end
        end
      end
      WAIT: begin
        m_stl = 1'b1;
        if (!i_m_cyc) begin
          state_next = IDLE;
          cnt_next   = 16'd0;
        end else if (sel_ack) begin
          m_ack      = 1'b1;
          m_data     = sel_data;
          state_next = IDLE;
          cnt_next   = 16'd0;
        end else if (cnt >= WAIT_LIMIT) begin
          state_next = ERR;
          cnt_next   = 16'd0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ERR: begin
        m_stl      = 1'b1;
        m_err      = i_m_cyc;
        cnt_next   = 16'd0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 16'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_intercon.sv
// tb/tb_wb_intercon.sv - directed self-checking bench for wb_intercon
module tb_wb_intercon;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_addr, m_data_in;
  logic        m_we, m_cyc, m_stb;
  logic [1:0]  m_width;
  logic [31:0] m_data;
  logic        m_ack, m_stl, m_err;
  logic [31:0] s_addr, s_data;
  logic        s_we, s_cyc;
  logic [1:0]  s_width;
  logic [2:0]  s_stb, s_ack, s_stl;
  logic [31:0] s0_data, s1_data, s2_data;

  int checks = 0;
  int errors = 0;

  wb_intercon #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_m_addr(m_addr), .i_m_data(m_data_in), .i_m_we(m_we), .i_m_cyc(m_cyc),
    .i_m_stb(m_stb), .i_m_width(m_width),
    .o_m_data(m_data), .o_m_ack(m_ack), .o_m_stl(m_stl), .o_m_err(m_err),
    .o_s_addr(s_addr), .o_s_data(s_data), .o_s_we(s_we), .o_s_cyc(s_cyc),
    .o_s_width(s_width), .o_s_stb(s_stb),
    .i_s_ack(s_ack), .i_s_stl(s_stl),
    .i_s0_data(s0_data), .i_s1_data(s1_data), .i_s2_data(s2_data)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic bus_idle();
    @(negedge clk);
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; s_ack = 3'b000; s_stl = 3'b000;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; m_addr = 32'd0; m_data_in = 32'd0; m_width = 2'd0;
    s0_data = 32'hdeadbeef; s1_data = 32'h11111111; s2_data = 32'h22222222;
    bus_idle();
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'hb0000010; s_ack = 3'b001; #1;
    checks++; if (s_stb !== 3'b000) begin errors++; $display("FAIL rst_stb got %b exp 000", s_stb); end
    checks++; if ({m_ack, m_err, m_stl} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {m_ack, m_err, m_stl}); end
    checks++; if (m_data !== 32'd0) begin errors++; $display("FAIL rst_data got %h exp 0", m_data); end
    @(negedge clk);
    reset = 1'b1; s_ack = 3'b000; #1;
    checks++; if (s_stb !== 3'b001 || m_stl !== 1'b0) begin errors++; $display("FAIL rst_first_accept got stb=%b stl=%b exp 001/0", s_stb, m_stl); end
    @(negedge clk);
    m_stb = 1'b0; s_ack = 3'b001; #1;
    checks++; if (m_ack !== 1'b1 || m_data !== 32'hdeadbeef) begin errors++; $display("FAIL rst_first_ack got %b/%h exp 1/deadbeef", m_ack, m_data); end
    bus_idle();
  endtask

  task automatic test_read_back_to_back();
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_addr = 32'hb0000010; #1;
    checks++; if (s_stb !== 3'b001 || m_stl !== 1'b0 || m_ack !== 1'b0) begin errors++; $display("FAIL read_req got stb=%b stl=%b ack=%b exp 001/0/0", s_stb, m_stl, m_ack); end
    @(negedge clk);
    m_stb = 1'b0; s_ack = 3'b001; #1;
    checks++; if (m_ack !== 1'b1 || m_data !== 32'hdeadbeef) begin errors++; $display("FAIL read_ack got %b/%h exp 1/deadbeef", m_ack, m_data); end
    checks++; if (s_stb !== 3'b000 || m_stl !== 1'b1) begin errors++; $display("FAIL read_wait got stb=%b stl=%b exp 000/1", s_stb, m_stl); end
    @(negedge clk);
    m_stb = 1'b1; m_addr = 32'hb0008000; s_ack = 3'b000; #1;
    checks++; if (s_stb !== 3'b010 || m_stl !== 1'b0 || m_ack !== 1'b0) begin errors++; $display("FAIL b2b_req got stb=%b stl=%b ack=%b exp 010/0/0", s_stb, m_stl, m_ack); end
    @(negedge clk);
    m_stb = 1'b0; s_ack = 3'b010; #1;
    checks++; if (m_ack !== 1'b1 || m_data !== 32'h11111111) begin errors++; $display("FAIL b2b_ack got %b/%h exp 1/11111111", m_ack, m_data); end
    bus_idle();
    checks++; if (m_ack !== 1'b0 || m_data !== 32'd0) begin errors++; $display("FAIL idle_out got %b/%h exp 0/0", m_ack, m_data); end
  endtask

  task automatic test_stall_write();
    int acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_addr = 32'hc0000000;
      m_data_in = 32'h41; m_width = 2'd2; s_stl = 3'b100; #1;
      checks++; if (s_stb !== 3'b100 || m_stl !== 1'b1) begin errors++; $display("FAIL wr_stall%0d got stb=%b stl=%b exp 100/1", i, s_stb, m_stl); end
      checks++; if (s_data !== 32'h41 || s_we !== 1'b1 || s_width !== 2'd2 || s_cyc !== 1'b1) begin errors++; $display("FAIL wr_pass%0d got %h/%b/%0d/%b exp 41/1/2/1", i, s_data, s_we, s_width, s_cyc); end
      acks += int'(m_ack);
    end
    @(negedge clk);
    s_stl = 3'b000; #1;
    checks++; if (s_stb !== 3'b100 || m_stl !== 1'b0) begin errors++; $display("FAIL wr_release got stb=%b stl=%b exp 100/0", s_stb, m_stl); end
    acks += int'(m_ack);
    @(negedge clk);
    m_stb = 1'b0; s_ack = 3'b011; #1;
    checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL wr_foreign_ack got %b exp 0", m_ack); end
    @(negedge clk);
    s_ack = 3'b100; #1;
    checks++; if (m_ack !== 1'b1 || m_data !== 32'h22222222) begin errors++; $display("FAIL wr_ack got %b/%h exp 1/22222222", m_ack, m_data); end
    acks += int'(m_ack);
    bus_idle();
    acks += int'(m_ack);
    checks++; if (acks != 1) begin errors++; $display("FAIL wr_ack_count got %0d exp 1", acks); end
  endtask

  task automatic test_unmapped();
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_addr = 32'ha0000000; #1;
    checks++; if (s_stb !== 3'b000 || m_stl !== 1'b1 || m_err !== 1'b0) begin errors++; $display("FAIL unmap_req got stb=%b stl=%b err=%b exp 000/1/0", s_stb, m_stl, m_err); end
    @(negedge clk);
    m_stb = 1'b0; s_ack = 3'b111; #1;
    checks++; if (m_err !== 1'b1 || m_ack !== 1'b0 || m_stl !== 1'b1 || m_data !== 32'd0) begin errors++; $display("FAIL unmap_err got err=%b ack=%b stl=%b data=%h exp 1/0/1/0", m_err, m_ack, m_stl, m_data); end
    @(negedge clk);
    s_ack = 3'b000; #1;
    checks++; if (m_err !== 1'b0 || m_stl !== 1'b0) begin errors++; $display("FAIL unmap_once got err=%b stl=%b exp 0/0", m_err, m_stl); end
    bus_idle();
  endtask

  task automatic test_wait_timeout();
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'hb0008000; #1;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      m_stb = 1'b0; #1;
      checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL wto_early%0d got %b exp 0", i, m_err); end
    end
    @(negedge clk); #1;
    checks++; if (m_err !== 1'b1 || m_ack !== 1'b0) begin errors++; $display("FAIL wto_err got err=%b ack=%b exp 1/0", m_err, m_ack); end
    @(negedge clk);
    s_ack = 3'b010; #1;
    checks++; if (m_ack !== 1'b0 || m_err !== 1'b0) begin errors++; $display("FAIL wto_stray got ack=%b err=%b exp 0/0", m_ack, m_err); end
    bus_idle();
  endtask

  task automatic test_stall_timeout();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'hb0000100; s_stl = 3'b001; #1;
      checks++; if (m_err !== 1'b0 || m_stl !== 1'b1) begin errors++; $display("FAIL sto_wait%0d got err=%b stl=%b exp 0/1", i, m_err, m_stl); end
    end
    @(negedge clk); #1;
    checks++; if (m_err !== 1'b1 || s_stb !== 3'b000) begin errors++; $display("FAIL sto_err got err=%b stb=%b exp 1/000", m_err, s_stb); end
    bus_idle();
  endtask

  task automatic test_ack_beats_timeout();
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'hb0000004; #1;
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      m_stb = 1'b0; #1;
    end
    @(negedge clk);
    s_ack = 3'b001; #1;
    checks++; if (m_ack !== 1'b1 || m_err !== 1'b0) begin errors++; $display("FAIL race_ack got ack=%b err=%b exp 1/0", m_ack, m_err); end
    @(negedge clk);
    s_ack = 3'b000; #1;
    checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL race_noerr got %b exp 0", m_err); end
    bus_idle();
  endtask

  task automatic test_abort();
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'hb0000000; #1;
    @(negedge clk);
    m_stb = 1'b0; #1;
    @(negedge clk);
    m_cyc = 1'b0; s_ack = 3'b001; #1;
    checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL abort_wait got ack=%b exp 0", m_ack); end
    @(negedge clk);
    m_cyc = 1'b1; #1;
    checks++; if (m_ack !== 1'b0 || m_err !== 1'b0) begin errors++; $display("FAIL abort_idle got ack=%b err=%b exp 0/0", m_ack, m_err); end
    bus_idle();
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'h00000000; #1;
    @(negedge clk);
    m_cyc = 1'b0; m_stb = 1'b0; #1;
    checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL abort_err got %b exp 0", m_err); end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'hb0008004; #1;
    @(negedge clk);
    m_stb = 1'b0; #1;
    @(negedge clk);
    reset = 1'b0; s_ack = 3'b010; #1;
    checks++; if ({m_ack, m_err, m_stl} !== 3'b000 || s_stb !== 3'b000 || m_data !== 32'd0) begin errors++; $display("FAIL mid_rst got ack/err/stl=%b stb=%b data=%h exp 000/000/0", {m_ack, m_err, m_stl}, s_stb, m_data); end
    @(negedge clk);
    reset = 1'b1; s_ack = 3'b000; m_stb = 1'b1; #1;
    checks++; if (s_stb !== 3'b010 || m_stl !== 1'b0 || m_ack !== 1'b0) begin errors++; $display("FAIL mid_rst_req got stb=%b stl=%b ack=%b exp 010/0/0", s_stb, m_stl, m_ack); end
    @(negedge clk);
    m_stb = 1'b0; s_ack = 3'b010; #1;
    checks++; if (m_ack !== 1'b1 || m_data !== 32'h11111111) begin errors++; $display("FAIL mid_rst_ack got %b/%h exp 1/11111111", m_ack, m_data); end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_read_back_to_back();
    test_stall_write();
    test_unmapped();
    test_wait_timeout();
    test_stall_timeout();
    test_ack_beats_timeout();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
